panel_input: RTL and testbench
==============================

// Module: panel_input
// PURPOSE
//  Front-panel producer for the CPU debug controller: scans a 4x4 hex keypad and debounces the
//  function buttons. Accumulates up to 4 hex digits into user_input/input_valid and emits one-cycle
//  b_* strobes. Its outputs wire straight to the debug controller's userInput/inputValid/b_* inputs.
// PARAMETERS
//  SCAN_DIV        1000  clk cycles each keypad row is driven before its columns are sampled (>=4)
//  DEBOUNCE_SCANS  4     consecutive full 4-row scans required to accept a key press or release
//  DEBOUNCE_CYC    50000 consecutive stable synchronized clk samples to flip a function button
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  row_n       out  4   keypad row drive, active-low, exactly one row low at a time
//  col_n       in   4   keypad columns, active-low (pulled up), asynchronous
//  fn_n        in   13  raw function buttons, active-low, async; bit map: 0 step, 1 reset, 2 runhalt,
//                       3 storeinc, 4 irq, 5 dec, 6 load, 7 toA, 8 toSP, 9 toX, 10 toY, 11 toPC, 12 clear
//  fn_pulse    out  12  one-cycle strobes for fn bits 0..11 (same map); clear has no strobe
//  user_input  out  16  entered value, last digit in [3:0]
//  input_valid out  1   1 when digit_count != 0
//  digit_count out  3   digits entered, saturates at 4
//  key_held    out  1   keypad debounced-pressed state (panel LED)
// BEHAVIOUR
//  Reset (sync): row_n=4'b1110, fn_pulse=0, user_input=0, digit_count=0, input_valid=0,
//   key_held=0; all counters, synchronizers and the FSM cleared. rst mid-debounce abandons it.
//  Synchronizers: col_n and fn_n pass through 2-flop synchronizers before any use.
//  Scan: row r held low SCAN_DIV cycles; synced col_n sampled on the last cycle; then row r+1
//   (3 wraps to 0). One full scan = 4 rows. key code = 4*r + c (0..15, the hex digit).
//   Multiple keys in one scan: lowest code wins.
//  Keypad FSM, advanced only at scan end:
//   IDLE: key seen -> PRESS_DEB with cand=code, cnt=1.
//   PRESS_DEB: same code -> cnt++; cnt reaches DEBOUNCE_SCANS -> HELD and accept cand.
//    Different code -> restart with new cand, cnt=1. No key -> IDLE.
//   HELD: no key -> RELEASE_DEB with cnt=1. Any key, including a different one, stays HELD;
//    no auto-repeat.
//   RELEASE_DEB: no key -> cnt++; cnt reaches DEBOUNCE_SCANS -> IDLE. Key seen -> HELD.
//   key_held=1 in HELD and RELEASE_DEB.
//  Accept (1 cycle, at the scan end completing debounce):
//   user_input <= {user_input[11:0], code}; digit_count <= min(digit_count+1, 4).
//   A 5th+ digit keeps shifting (oldest lost); count stays 4.
//  Fn buttons: per-bit counter. Synced level differs from debounced state for DEBOUNCE_CYC
//   consecutive cycles -> state flips. A bounce back resets the counter.
//   Press edge (state 0->1) on bits 0..11 -> fn_pulse[bit]=1 for exactly one cycle.
//   Release produces nothing. Several buttons may strobe in the same cycle.
//  Entry clear: the cycle after any fn_pulse bit, or on a clear press edge:
//   user_input<=0, digit_count<=0. So the consumer samples user_input/input_valid in the same
//   cycle as the strobe, with the old value.
//   Clear and digit accept in the same cycle: clear first, then shift ->
//   user_input={12'h000,code}, digit_count=1.
//  Latency: fn_pulse fires DEBOUNCE_CYC+2 cycles after a clean press (2-flop sync + counter).
// TESTING
//  SCAN_DIV=4, DEBOUNCE_SCANS=2, DEBOUNCE_CYC=8 for all directed tests.
//  1. Reset: rst high 2 cycles -> row_n=1110, user_input=0000, input_valid=0, fn_pulse=0;
//     rows then cycle 1101,1011,0111,1110 every 4 clks.
//  2. Press keys 1,2,3,4,5 in turn, each held 3 scans then released -> user_input=2345,
//     digit_count=4, input_valid=1; exactly one accept per press.
//  3. Press A, then press load (fn_n[6]) clean -> fn_pulse[6] high 1 cycle with user_input=000A,
//     input_valid=1; next cycle user_input=0, input_valid=0.
//  4. Bounce: toggle fn_n[0] every 3 clks for 30 clks, then hold low -> exactly one fn_pulse[0],
//     10 clks after the final edge; none during bounce.
//  5. Keys 3 and 9 together (rows 0/2) -> digit 3 accepted once; release 3 keeping 9 -> no new
//     accept until full release.
//  6. Press clear with digit_count=2 -> user_input=0, digit_count=0, no fn_pulse; assert rst
//     mid PRESS_DEB -> no accept.

Source files
------------

// File: rtl/panel_input.sv
// Front-panel producer: scans a 4x4 hex keypad, debounces function buttons,
// accumulates up to four hex digits and emits one-cycle function strobes.
module panel_input #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned DEBOUNCE_CYC   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic [12:0] fn_n,
  output logic [11:0] fn_pulse,
  output logic [15:0] user_input,
  output logic        input_valid,
  output logic [2:0]  digit_count,
  output logic        key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned SCN_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned FCW   = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DEB,
    S_HELD,
    S_RELEASE_DEB
  } key_state_t;

  logic [3:0]  col_s1, col_s2;
  logic [12:0] fn_s1, fn_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
      fn_s1  <= '1;
      fn_s2  <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      fn_s1  <= fn_n;
      fn_s2  <= fn_s1;
    end
  end

  // ---------------- keypad scan ----------------
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic             scan_found_q;
  logic [3:0]       scan_code_q;
  logic [3:0]       col_act;
  logic             row_hit;
  logic [1:0]       row_col;
  logic             sample, scan_end;
  logic             key_seen;
  logic [3:0]       key_code;

  assign row_n = ~(4'b0001 << row_q);

  always_comb begin
    col_act = ~col_s2;
    row_hit = |col_act;
    if (col_act[0])      row_col = 2'd0;
    else if (col_act[1]) row_col = 2'd1;
    else if (col_act[2]) row_col = 2'd2;
    else                 row_col = 2'd3;
    sample   = (div_q == DIV_W'(SCAN_DIV - 1));
    scan_end = sample && (row_q == 2'd3);
    // Rows are visited in ascending order, so the first hit holds the lowest code.
    key_seen = scan_found_q || (sample && row_hit);
    key_code = scan_found_q ? scan_code_q : {row_q, row_col};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      row_q        <= '0;
      scan_found_q <= 1'b0;
      scan_code_q  <= '0;
    end else if (sample) begin
      div_q <= '0;
      row_q <= row_q + 2'd1;
      if (scan_end) begin
        scan_found_q <= 1'b0;
      end else if (!scan_found_q && row_hit) begin
        scan_found_q <= 1'b1;
        scan_code_q  <= {row_q, row_col};
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // ---------------- keypad debounce FSM ----------------
  key_state_t       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [SCN_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [3:0]       accept_code;
  logic             cnt_done;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    accept_code = cand_q;
    cnt_done    = (int'(cnt_q) + 1 >= int'(DEBOUNCE_SCANS));
    if (scan_end) begin
      case (state_q)
        S_IDLE: begin
          if (key_seen) begin
            cand_d = key_code;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d     = S_HELD;
              cnt_d       = '0;
              accept      = 1'b1;
              accept_code = key_code;
            end else begin
              state_d = S_PRESS_DEB;
              cnt_d   = SCN_W'(1);
            end
          end
        end
        S_PRESS_DEB: begin
          if (!key_seen) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (key_code == cand_q) begin
            if (cnt_done) begin
              state_d = S_HELD;
              cnt_d   = '0;
              accept  = 1'b1;
            end else begin
              cnt_d = cnt_q + SCN_W'(1);
            end
          end else begin
            cand_d = key_code;
            cnt_d  = SCN_W'(1);
          end
        end
        S_HELD: begin
          if (!key_seen) begin
            state_d = (DEBOUNCE_SCANS <= 1) ? S_IDLE : S_RELEASE_DEB;
            cnt_d   = (DEBOUNCE_SCANS <= 1) ? '0 : SCN_W'(1);
          end
        end
        S_RELEASE_DEB: begin
          if (key_seen) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SCN_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_held = (state_q == S_HELD) || (state_q == S_RELEASE_DEB);

  // ---------------- function button debounce ----------------
  logic [12:0]    fn_state_q, fn_state_d;
  logic [FCW-1:0] fn_cnt_q [13];
  logic [FCW-1:0] fn_cnt_d [13];
  logic [12:0]    fn_rise;

  always_comb begin
    fn_state_d = fn_state_q;
    fn_rise    = '0;
    for (int unsigned i = 0; i < 13; i++) begin
      fn_cnt_d[i] = '0;
      if (!fn_s2[i] != fn_state_q[i]) begin
        if (fn_cnt_q[i] == FCW'(DEBOUNCE_CYC - 1)) begin
          fn_state_d[i] = !fn_state_q[i];
          fn_rise[i]    = !fn_state_q[i];
        end else begin
          fn_cnt_d[i] = fn_cnt_q[i] + FCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fn_state_q <= '0;
      fn_pulse   <= '0;
      for (int unsigned i = 0; i < 13; i++) fn_cnt_q[i] <= '0;
    end else begin
      fn_state_q <= fn_state_d;
      fn_pulse   <= fn_rise[11:0];
      for (int unsigned i = 0; i < 13; i++) fn_cnt_q[i] <= fn_cnt_d[i];
    end
  end

  // ---------------- digit entry ----------------
  // Clear lands one cycle after a strobe so the consumer sees the old value with it.
  logic clr;
  assign clr = (|fn_pulse) || fn_rise[12];

  always_ff @(posedge clk) begin
    if (rst) begin
      user_input  <= '0;
      digit_count <= '0;
    end else if (accept) begin
      user_input  <= {(clr ? 12'h000 : user_input[11:0]), accept_code};
      digit_count <= clr ? 3'd1 : ((digit_count >= 3'd4) ? 3'd4 : digit_count + 3'd1);
    end else if (clr) begin
      user_input  <= '0;
      digit_count <= '0;
    end
  end

  assign input_valid = (digit_count != 3'd0);

endmodule

// File: tb/tb_panel_input.sv
// Directed bench for panel_input: keypad scan/debounce, digit entry, function strobes and clear.
module tb_panel_input;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [12:0] fn_n;
  logic [11:0] fn_pulse;
  logic [15:0] user_input;
  logic        input_valid;
  logic [2:0]  digit_count;
  logic        key_held;
  logic [15:0] keys;

  int checks = 0;
  int passed = 0;

  localparam int SCAN = 16;

  panel_input #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2),
    .DEBOUNCE_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_n(row_n),
    .col_n(col_n),
    .fn_n(fn_n),
    .fn_pulse(fn_pulse),
    .user_input(user_input),
    .input_valid(input_valid),
    .digit_count(digit_count),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic press_key(input logic [15:0] k, input int hold, input int rel, input string name);
    keys = k;
    repeat (hold * SCAN) @(negedge clk);
    check({name, " key_held"}, 32'(key_held), 32'd1);
    keys = '0;
    repeat (rel * SCAN) @(negedge clk);
    check({name, " released"}, 32'(key_held), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  key;
    logic [15:0] exp_ui;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs [5];
  logic [3:0] exp_rows [4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int npulse;
    logic any;

    vecs[0] = '{4'h1, 16'h0001, 3'd1};
    vecs[1] = '{4'h2, 16'h0012, 3'd2};
    vecs[2] = '{4'h3, 16'h0123, 3'd3};
    vecs[3] = '{4'h4, 16'h1234, 3'd4};
    vecs[4] = '{4'h5, 16'h2345, 3'd4};
    exp_rows[0] = 4'b1101;
    exp_rows[1] = 4'b1011;
    exp_rows[2] = 4'b0111;
    exp_rows[3] = 4'b1110;

    // 1. reset state and row rotation
    rst  = 1'b1;
    keys = '0;
    fn_n = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst row_n", 32'(row_n), 32'hE);
    check("rst user_input", 32'(user_input), 32'h0);
    check("rst input_valid", 32'(input_valid), 32'h0);
    check("rst fn_pulse", 32'(fn_pulse), 32'h0);
    check("rst digit_count", 32'(digit_count), 32'h0);
    check("rst key_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check("row rotate", 32'(row_n), 32'(exp_rows[i]));
    end

    // 2. table of single-key presses
    for (int i = 0; i < 5; i++) begin
      press_key(16'(1) << vecs[i].key, 3, 4, "table");
      check("table user_input", 32'(user_input), 32'(vecs[i].exp_ui));
      check("table digit_count", 32'(digit_count), 32'(vecs[i].exp_cnt));
      check("table input_valid", 32'(input_valid), 32'd1);
    end

    // 4. bouncing fn_n[0]: one strobe 10 clocks after the final edge
    first = -1;
    npulse = 0;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (fn_pulse[0]) begin
        npulse++;
        if (first < 0) first = k;
      end
      if (k < 30 && (k % 3) == 0) fn_n[0] = ((k / 3) % 2 == 1);
      else if (k == 30) fn_n[0] = 1'b0;
    end
    check("bounce pulse count", 32'(npulse), 32'd1);
    check("bounce pulse time", 32'(first), 32'd40);
    check("bounce clears entry", 32'(digit_count), 32'd0);
    fn_n[0] = 1'b1;
    repeat (20) @(negedge clk);

    // 5. keys 3 and 9 together: lowest code wins, no accept until full release
    keys = (16'(1) << 3) | (16'(1) << 9);
    repeat (3 * SCAN) @(negedge clk);
    check("dual user_input", 32'(user_input), 32'h0003);
    check("dual digit_count", 32'(digit_count), 32'd1);
    keys = 16'(1) << 9;
    repeat (4 * SCAN) @(negedge clk);
    check("dual hold9 user_input", 32'(user_input), 32'h0003);
    check("dual hold9 key_held", 32'(key_held), 32'd1);
    keys = '0;
    repeat (4 * SCAN) @(negedge clk);
    check("dual released", 32'(key_held), 32'd0);
    press_key(16'(1) << 9, 3, 4, "key9");
    check("key9 user_input", 32'(user_input), 32'h0039);
    check("key9 digit_count", 32'(digit_count), 32'd2);

    // 6a. clear button: entry zeroed on the debounced press edge, no strobe
    any = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(negedge clk);
        any = any | (|fn_pulse);
        if (k == 9) check("clear before edge", 32'(user_input), 32'h0039);
        if (k == 10) begin
          check("clear user_input", 32'(user_input), 32'h0);
          check("clear digit_count", 32'(digit_count), 32'd0);
        end
      end
      if (k == 0) fn_n[12] = 1'b0;
    end
    check("clear no strobe", 32'(any), 32'd0);
    fn_n[12] = 1'b1;
    repeat (20) @(negedge clk);

    // 3. key A then load: strobe carries the old entry, cleared next cycle
    press_key(16'(1) << 10, 3, 4, "keyA");
    check("keyA user_input", 32'(user_input), 32'h000A);
    fn_n[6] = 1'b0;
    first = -1;
    for (int k = 1; k <= 30 && first < 0; k++) begin
      @(negedge clk);
      if (fn_pulse[6]) first = k;
    end
    check("load latency", 32'(first), 32'd10);
    check("load user_input", 32'(user_input), 32'h000A);
    check("load input_valid", 32'(input_valid), 32'd1);
    @(negedge clk);
    check("load one cycle", 32'(fn_pulse), 32'h0);
    check("load cleared ui", 32'(user_input), 32'h0);
    check("load cleared valid", 32'(input_valid), 32'd0);
    fn_n[6] = 1'b1;
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (|fn_pulse) npulse++;
    end
    check("load release silent", 32'(npulse), 32'd0);

    // 6b. reset in the middle of PRESS_DEB abandons the debounce
    first = 0;
    while (row_n != 4'b0111 && first < 40) begin
      @(negedge clk);
      first++;
    end
    while (row_n != 4'b1110 && first < 40) begin
      @(negedge clk);
      first++;
    end
    check("scan align", 32'(row_n), 32'hE);
    keys = 16'(1) << 1;
    repeat (20) @(negedge clk);
    check("pre-rst key_held", 32'(key_held), 32'd0);
    check("pre-rst digit_count", 32'(digit_count), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst mid deb no accept", 32'(digit_count), 32'd0);
    repeat (20) @(negedge clk);
    check("post-rst accept count", 32'(digit_count), 32'd1);
    check("post-rst accept ui", 32'(user_input), 32'h0001);
    keys = '0;
    repeat (4 * SCAN) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
